comm_tx_sched: RTL and testbench

Transmit scheduler between the J1 I/O bus and the communications UART transmitter. Firmware pushes bytes into an internal FIFO at chip-select 0x99xx. The block then feeds them one at a time to the TX core over a start/busy handshake, with a programmable inter-byte gap. A status register lets firmware poll fill level and errors instead of busy-waiting per byte.

---
 rtl/comm_tx_pkg.sv | 29 ++
 rtl/comm_tx_fifo.sv | 50 +++++
 rtl/comm_tx_sched.sv | 119 +++++++++++
 tb/tb_comm_tx_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/comm_tx_pkg.sv
// comm_tx_pkg: register map, status layout and FSM encoding shared by the TX scheduler
package comm_tx_pkg;
    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_CTRL   = 4'h2;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_GAP    = 4'h6;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_TMO   = 4;
    localparam int ST_COUNT = 7;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_FLUSH = 1;
    localparam int CTRL_CLR   = 2;

    localparam int ACK_TMO = 15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_START,
        S_ACK,
        S_DONE,
        S_GAP
    } state_t;
endpackage

// File: rtl/comm_tx_fifo.sv
// comm_tx_fifo: byte FIFO with flush; full/empty registered from the next-cycle count
module comm_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic [8:0] count,
    output logic [8:0] count_nxt,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    // a pop frees the slot being written, so a push at full still lands
    assign do_push   = push & (!full | pop) & !flush;
    assign do_pop    = pop & !empty & !flush;
    assign count_nxt = flush ? 9'd0 : count + 9'(do_push) - 9'(do_pop);
    assign head      = mem[rptr];

    // pointers, count and flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            wptr  <= flush ? '0 : do_push ? wptr + AW'(1) : wptr;
            rptr  <= flush ? '0 : do_pop ? rptr + AW'(1) : rptr;
            count <= count_nxt;
            full  <= count_nxt == 9'(DEPTH);
            empty <= count_nxt == 9'd0;
        end
    end

    // storage needs no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

// File: rtl/comm_tx_sched.sv
// comm_tx_sched: J1-visible TX FIFO feeding the UART TX core with a programmable inter-byte gap
module comm_tx_sched
    import comm_tx_pkg::*;
#(
    parameter int          DEPTH   = 16,
    parameter logic [15:0] GAP_RST = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        irq_empty
);
    state_t      state, state_nxt;
    logic        en, ovf, tmo, tmo_set, ovf_set;
    logic        wr_data, wr_ctrl, wr_gap, flush, clr, pop;
    logic [15:0] gap_reg, gap_cur, tmr, status;
    logic [7:0]  head;
    logic [8:0]  count, count_nxt;
    logic        full, empty;

    assign wr_data = cs & wr & (addr == REG_DATA);
    assign wr_ctrl = cs & wr & (addr == REG_CTRL);
    assign wr_gap  = cs & wr & (addr == REG_GAP);
    assign flush   = wr_ctrl & d_in[CTRL_FLUSH];
    assign clr     = wr_ctrl & d_in[CTRL_CLR];
    assign pop     = state == S_POP;
    assign ovf_set = wr_data & full & !pop & !flush;

    comm_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_data),
        .pop       (pop),
        .flush     (flush),
        .din       (d_in[7:0]),
        .head      (head),
        .count     (count),
        .count_nxt (count_nxt),
        .full      (full),
        .empty     (empty)
    );

    // next state; tmr restarts on every state change and times both ACK and GAP
    always_comb begin
        state_nxt = state;
        tmo_set   = 1'b0;
        case (state)
            S_IDLE:  if (en && !empty && !tx_busy) state_nxt = S_POP;
            S_POP:   state_nxt = S_START;
            S_START: state_nxt = S_ACK;
            S_ACK: begin
                if (tx_busy) state_nxt = S_DONE;
                else if (tmr == 16'(ACK_TMO - 1)) begin
                    state_nxt = S_GAP;
                    tmo_set   = 1'b1;
                end
            end
            S_DONE:  if (!tx_busy) state_nxt = S_GAP;
            S_GAP:   if (tmr == gap_cur) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM state, timer and registered TX-side outputs; gap is sampled per byte at POP
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            tmr       <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            gap_cur   <= '0;
            irq_empty <= 1'b1;
        end else begin
            state     <= state_nxt;
            tmr       <= (state_nxt != state) ? '0 : tmr + 16'd1;
            tx_start  <= state_nxt == S_START;
            tx_data   <= pop ? head : tx_data;
            gap_cur   <= pop ? gap_reg : gap_cur;
            irq_empty <= (count_nxt == 9'd0) && (state_nxt == S_IDLE);
        end
    end

    // firmware control registers and sticky error flags; a new error wins over a clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            en      <= 1'b0;
            ovf     <= 1'b0;
            tmo     <= 1'b0;
            gap_reg <= GAP_RST;
        end else begin
            en      <= wr_ctrl ? d_in[CTRL_EN] : en;
            ovf     <= ovf_set | (ovf & !clr);
            tmo     <= tmo_set | (tmo & !clr);
            gap_reg <= wr_gap ? d_in : gap_reg;
        end
    end

    // read mux, zero unless a read strobe hits a readable register
    always_comb begin
        status                  = '0;
        status[ST_COUNT +: 9]   = count;
        status[ST_TMO]          = tmo;
        status[ST_OVF]          = ovf;
        status[ST_BUSY]         = state != S_IDLE;
        status[ST_FULL]         = full;
        status[ST_EMPTY]        = empty;
        d_out = !(cs && rd) ? 16'd0 :
                addr == REG_STATUS ? status :
                addr == REG_GAP ? gap_reg : 16'd0;
    end
endmodule

// File: tb/tb_comm_tx_sched.sv
// tb_comm_tx_sched: directed vectors against a simple TX-core model
module tb_comm_tx_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] d_in = '0;
    logic        cs = 1'b0;
    logic [3:0]  addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] d_out;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic        irq_empty;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          bcnt = 0;
    int          fall_cyc = 0;
    int          spacing = 0;
    int          n_start = 0;
    bit          ignore = 1'b0;
    logic [7:0]  sent_q[$];
    logic [15:0] v;
    int          base;

    comm_tx_sched #(.DEPTH(16), .GAP_RST(16'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .cs        (cs),
        .addr      (addr),
        .rd        (rd),
        .wr        (wr),
        .d_out     (d_out),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .irq_empty (irq_empty)
    );

    always #5 clk = ~clk;

    // TX core model: busy for 10 cycles after each start unless told to ignore starts
    always @(negedge clk) begin
        cyc++;
        if (tx_start) begin
            sent_q.push_back(tx_data);
            n_start++;
            spacing = cyc - fall_cyc;
        end
        if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) begin
                tx_busy  = 1'b0;
                fall_cyc = cyc;
            end
        end else if (tx_start && !ignore) begin
            tx_busy = 1'b1;
            bcnt    = 10;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
        tick();
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        tick();
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [3:0] a, input logic c, output logic [15:0] val);
        cs = c; rd = 1'b1; addr = a;
        #1;
        val = d_out;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        bit ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            tick();
            ok = irq_empty && !tx_busy;
        end
        check(tag, ok, 1);
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        rst = 1'b1;
        repeat (5) tick();
        rd_reg(4'h4, 1'b1, v);
        check("rst_status", v, 16'h0001);
        check("rst_irq", irq_empty, 1);
        check("rst_nostart", n_start, 0);
        check("rst_txdata", tx_data, 0);
        rd_reg(4'h8, 1'b1, v);
        check("rd_unmapped", v, 0);
        rd_reg(4'h4, 1'b0, v);
        check("rd_no_cs", v, 0);

        // three bytes, GAP=0
        wr_reg(4'h6, 16'd0);
        wr_reg(4'h2, 16'h0001);
        sent_q.delete();
        wr_reg(4'h0, 16'h0041);
        tick();
        check("start_n1", tx_start, 0);
        tick();
        check("start_n2", tx_start, 1);
        check("start_data", tx_data, 8'h41);
        wr_reg(4'h0, 16'h0042);
        wr_reg(4'h0, 16'h0043);
        wait_idle("idle3", 300);
        check("sent3_n", sent_q.size(), 3);
        check("sent3_0", sent_q[0], 8'h41);
        check("sent3_1", sent_q[1], 8'h42);
        check("sent3_2", sent_q[2], 8'h43);
        check("b2b_spacing", spacing, 4);
        rd_reg(4'h4, 1'b1, v);
        check("st_after3", v, 16'h0001);
        check("irq_after3", irq_empty, 1);

        // overflow, then push+pop at full
        wr_reg(4'h2, 16'h0000);
        sent_q.delete();
        for (int i = 0; i < 17; i++) wr_reg(4'h0, 16'(i));
        rd_reg(4'h4, 1'b1, v);
        check("st_full_ovf", v, 16'h080A);
        check("irq_full", irq_empty, 0);
        wr_reg(4'h2, 16'h0004);
        rd_reg(4'h4, 1'b1, v);
        check("st_clr_ovf", v, 16'h0802);
        wr_reg(4'h2, 16'h0001);
        wr_reg(4'h0, 16'h0055);
        rd_reg(4'h4, 1'b1, v);
        check("st_pushpop_full", v, 16'h0806);
        wait_idle("idle17", 800);
        check("sent17_n", sent_q.size(), 17);
        check("sent17_0", sent_q[0], 8'h00);
        check("sent17_15", sent_q[15], 8'h0F);
        check("sent17_16", sent_q[16], 8'h55);

        // programmable gap
        wr_reg(4'h6, 16'd100);
        rd_reg(4'h6, 1'b1, v);
        check("gap_rd", v, 16'd100);
        sent_q.delete();
        wr_reg(4'h0, 16'h0001);
        wr_reg(4'h0, 16'h0002);
        wait_idle("idle_gap", 600);
        check("gap_n", sent_q.size(), 2);
        check("gap_spacing", spacing, 104);

        // ACK timeout
        wr_reg(4'h6, 16'd0);
        ignore = 1'b1;
        sent_q.delete();
        wr_reg(4'h0, 16'h0061);
        tick();
        tick();
        check("tmo_start", tx_start, 1);
        wr_reg(4'h0, 16'h0062);
        repeat (13) tick();
        rd_reg(4'h4, 1'b1, v);
        check("tmo_before", v[4], 0);
        tick();
        rd_reg(4'h4, 1'b1, v);
        check("tmo_after", v[4], 1);
        wait_idle("idle_tmo", 200);
        check("tmo_n", sent_q.size(), 2);
        check("tmo_next", sent_q[1], 8'h62);
        rd_reg(4'h4, 1'b1, v);
        check("st_tmo", v, 16'h0011);
        wr_reg(4'h2, 16'h0005);
        rd_reg(4'h4, 1'b1, v);
        check("st_tmo_clr", v, 16'h0001);

        // flush while DONE
        ignore = 1'b0;
        wr_reg(4'h2, 16'h0000);
        sent_q.delete();
        for (int i = 0; i < 6; i++) wr_reg(4'h0, 16'(8'h70 + i));
        wr_reg(4'h2, 16'h0001);
        tick();
        tick();
        check("fl_start", tx_start, 1);
        repeat (3) tick();
        wr_reg(4'h2, 16'h0003);
        rd_reg(4'h4, 1'b1, v);
        check("st_flushed", v, 16'h0005);
        wait_idle("idle_flush", 100);
        repeat (20) tick();
        check("fl_n", sent_q.size(), 1);
        check("fl_byte", sent_q[0], 8'h70);
        rd_reg(4'h4, 1'b1, v);
        check("st_fl_end", v, 16'h0001);

        // reset mid-ACK
        ignore = 1'b1;
        wr_reg(4'h0, 16'h0080);
        tick();
        tick();
        check("rs_start", tx_start, 1);
        wr_reg(4'h0, 16'h0081);
        tick();
        rst = 1'b0;
        tick();
        check("rs_txstart", tx_start, 0);
        check("rs_irq", irq_empty, 1);
        check("rs_txdata", tx_data, 0);
        rd_reg(4'h4, 1'b1, v);
        check("rs_status", v, 16'h0001);
        rst = 1'b1;
        ignore = 1'b0;
        base = n_start;
        repeat (20) tick();
        check("rs_nostart", n_start, base);
        rd_reg(4'h6, 1'b1, v);
        check("rs_gap", v, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
